parity3_sweep_ctrl: RTL and testbench
=====================================

// Module: parity3_sweep_ctrl
// PURPOSE
// - Sequencer for the 3-input gate-level parity/XNOR function block (minterms 0,3,5,6; f = ~(A^B^C)).
// - On start, drives the block's inputs through all 2**N_IN vectors and samples f after a settle window.
// - Compares each sample against a golden truth table and reports the observed mask, mismatch count,
//   first failing vector and pass/fail.
// - Sits between the lab bench/top-level and the combinational block; it is the block's only driver.
// PARAMETERS
// - N_IN           3      number of function inputs; vectors 0 .. 2**N_IN-1
// - SETTLE_CYCLES  2      cycles a vector is held before sampling; legal range >= 1
// - GOLDEN         8'h69  expected f per vector index; bit i = f(i)
// PORTS
// - clk       in   1        rising-edge clock
// - rst_n     in   1        asynchronous, active-low reset
// - start     in   1        level-sampled; accepted only in IDLE
// - dut_in    out  N_IN     {A,B,C} to the function block; A = MSB
// - dut_f     in   1        function block output; combinational from dut_in
// - busy      out  1        high from the start-accept edge until DONE is left
// - done      out  1        1-cycle pulse while in DONE
// - pass      out  1        obs_mask == GOLDEN for the last sweep; held until next start
// - err_cnt   out  N_IN+1   number of mismatching vectors in the last sweep
// - fail_idx  out  N_IN     lowest mismatching vector index; 0 when err_cnt == 0
// - obs_mask  out  2**N_IN  captured f per vector index
// BEHAVIOUR
// - Reset values: dut_in=0, busy=0, done=0, pass=0, err_cnt=0, fail_idx=0, obs_mask=0; state=IDLE.
// - States:
//   IDLE   -> WAIT   on start=1; same edge: idx=0, settle cnt=0, and obs_mask, err_cnt, fail_idx, pass cleared.
//   WAIT   -> SAMPLE when cnt == SETTLE_CYCLES-1; otherwise cnt++.
//   SAMPLE : obs_mask[idx] <= dut_f. On dut_f != GOLDEN[idx]: err_cnt++, and fail_idx <= idx if first mismatch.
//            -> DONE if idx == 2**N_IN-1; else idx++, cnt=0, -> WAIT.
//   DONE   -> IDLE   unconditionally; done=1 in this state only; pass <= (final mask == GOLDEN).
// - Vector timing:
//   - dut_in follows idx and is registered.
//   - Each vector is held exactly SETTLE_CYCLES+1 cycles; dut_f is sampled on the last edge of that window.
//   - DONE is entered 2**N_IN*(SETTLE_CYCLES+1) edges after the start-accept edge (24 at defaults).
// - start while busy is ignored, with no queueing.
// - start held high through DONE: state returns to IDLE, then a new sweep is accepted on the next edge.
// - Results stay stable between sweeps; dut_in stays at the last vector (7) after DONE until the next start.
// - Reset mid-sweep returns immediately to reset values; no partial results are kept.
// - err_cnt saturation is impossible: its width holds 2**N_IN.
// CONFIGURATION
// - SWEEP_STOP_ON_FAIL_EN
//   - Defined: the first mismatching SAMPLE goes directly to DONE. err_cnt=1, fail_idx=that idx,
//     obs_mask bits above idx remain 0, pass=0.
//   - Undefined: full sweep is always performed.
// STRUCTURE
// - Package parity3_sweep_pkg: state enum {IDLE, WAIT, SAMPLE, DONE}, N_IN_DEF, SETTLE_DEF, GOLDEN_XNOR3 = 8'h69.
// - One sub-module: sweep_settle_cnt (load / count / terminal-count flag for the WAIT window).
// - All other logic (FSM, idx counter, scoreboard registers) is flat in this module.
// TESTING
// 1. Correct XNOR3 model, start pulse -> done at edge 24, pass=1, obs_mask=8'h69, err_cnt=0, fail_idx=0.
// 2. dut_f stuck-at-0 -> obs_mask=8'h00, err_cnt=4, fail_idx=0, pass=0.
// 3. Fault only at vector 5 (f=1):
//    - Macro off: obs_mask=8'h49, err_cnt=1, fail_idx=5, done at edge 24.
//    - Macro on: done at edge 18, obs_mask=8'h09.
// 4. start re-pulsed at edges 3 and 10 of a sweep -> ignored; done once at edge 24.
//    start held high -> back-to-back sweeps, results cleared at each accept.
// 5. rst_n low during vector 4 -> all outputs 0 asynchronously; next start gives a full correct sweep (as test 1).
// 6. SETTLE_CYCLES=1 -> each vector held 2 cycles, done at edge 16; dut_in sequence 0..7 checked cycle by cycle.

Source files
------------

// File: rtl/parity3_sweep_pkg.sv
// Shared types and defaults for the XNOR3 truth-table sweep sequencer.
package parity3_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SAMPLE,
        DONE
    } sweep_state_e;

    localparam int         N_IN_DEF     = 3;
    localparam int         SETTLE_DEF   = 2;
    localparam logic [7:0] GOLDEN_XNOR3 = 8'h69;

endpackage

// File: rtl/sweep_settle_cnt.sv
// Settle-window counter: cleared by load, counts on en, tc marks the last WAIT cycle.
module sweep_settle_cnt
    import parity3_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = SETTLE_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic tc
);

    localparam int             W      = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [W-1:0]   TC_VAL = W'(SETTLE_CYCLES - 1);

    logic [W-1:0] cnt;

    // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

    assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/parity3_sweep_ctrl.sv
// Drives all input vectors of the XNOR3 block, samples f and scores it against GOLDEN.
// Optional build macro SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module parity3_sweep_ctrl
    import parity3_sweep_pkg::*;
#(
    parameter int                 N_IN          = N_IN_DEF,
    parameter int                 SETTLE_CYCLES = SETTLE_DEF,
    parameter logic [2**N_IN-1:0] GOLDEN        = GOLDEN_XNOR3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [N_IN-1:0]      dut_in,
    input  logic                 dut_f,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        err_cnt,
    output logic [N_IN-1:0]      fail_idx,
    output logic [2**N_IN-1:0]   obs_mask
);

    localparam logic [N_IN-1:0] LAST_IDX = '1;

    sweep_state_e    state, state_d;
    logic [N_IN-1:0] idx;
    logic            settle_tc;
    logic            accept;
    logic            mismatch;
    logic            stop_early;

    sweep_settle_cnt #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (state != WAIT),
        .en    ((state == WAIT) && !settle_tc),
        .tc    (settle_tc)
    );

    assign accept   = (state == IDLE) && start;
    assign mismatch = (dut_f != GOLDEN[idx]);

`ifdef SWEEP_STOP_ON_FAIL_EN
    assign stop_early = mismatch;
`else
    assign stop_early = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // NOTE: state_d gets its default before the case, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (start) state_d = WAIT;
            WAIT:    if (settle_tc) state_d = SAMPLE;
            SAMPLE:  state_d = ((idx == LAST_IDX) || stop_early) ? DONE : WAIT;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The vector index doubles as the registered drive to the block, so it parks on the last vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            obs_mask <= '0;
            err_cnt  <= '0;
            fail_idx <= '0;
            pass     <= 1'b0;
        end else if (accept) begin
            idx      <= '0;
            obs_mask <= '0;
            err_cnt  <= '0;
            fail_idx <= '0;
            pass     <= 1'b0;
        end else if (state == SAMPLE) begin
            obs_mask[idx] <= dut_f;
            if (mismatch) begin
                err_cnt <= err_cnt + (N_IN+1)'(1);
                if (err_cnt == '0) fail_idx <= idx;
            end
            if (state_d == WAIT) idx <= idx + N_IN'(1);
        end else if (state == DONE) begin
            pass <= (obs_mask == GOLDEN);
        end
    end

    assign dut_in = idx;
    assign busy   = (state != IDLE);
    assign done   = (state == DONE);

endmodule

// File: tb/tb_parity3_sweep_ctrl.sv
// Self-checking bench: two sequencers (settle 2 and 1) driving a faultable XNOR3 model.
module tb_parity3_sweep_ctrl;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start0 = 1'b0, start1 = 1'b0;
    logic [2:0] din0, din1;
    logic       f0, f1;
    logic       busy0, busy1, done0, done1, pass0, pass1;
    logic [3:0] ec0, ec1;
    logic [2:0] fi0, fi1;
    logic [7:0] om0, om1;
    logic [7:0] fault = 8'h00;
    int         sel = 0;
    int         checks = 0;
    int         errors = 0;

    logic [2:0] o_din;
    logic       o_busy, o_done, o_pass;
    logic [3:0] o_ec;
    logic [2:0] o_fi;
    logic [7:0] o_om;

    always #5 clk = ~clk;

    function automatic logic spec_f(input logic [2:0] v);
        return ~(v[2] ^ v[1] ^ v[0]);
    endfunction

    function automatic logic [7:0] golden_mask();
        logic [7:0] m;
        for (int v = 0; v < 8; v++) m[v] = spec_f(3'(v));
        return m;
    endfunction

    assign f0 = spec_f(din0) ^ fault[din0];
    assign f1 = spec_f(din1) ^ fault[din1];

    parity3_sweep_ctrl dut0 (
        .clk (clk), .rst_n (rst_n), .start (start0), .dut_in (din0), .dut_f (f0),
        .busy (busy0), .done (done0), .pass (pass0), .err_cnt (ec0), .fail_idx (fi0),
        .obs_mask (om0)
    );

    parity3_sweep_ctrl #(.SETTLE_CYCLES (1)) dut1 (
        .clk (clk), .rst_n (rst_n), .start (start1), .dut_in (din1), .dut_f (f1),
        .busy (busy1), .done (done1), .pass (pass1), .err_cnt (ec1), .fail_idx (fi1),
        .obs_mask (om1)
    );

    always_comb begin
        o_din = din0; o_busy = busy0; o_done = done0; o_pass = pass0;
        o_ec  = ec0;  o_fi   = fi0;   o_om   = om0;
        if (sel == 1) begin
            o_din = din1; o_busy = busy1; o_done = done1; o_pass = pass1;
            o_ec  = ec1;  o_fi   = fi1;   o_om   = om1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive_start(input int s, input logic v);
        if (s == 1) start1 = v;
        else        start0 = v;
    endtask

    task automatic check_all_zero(input string tag);
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #0;
            check({tag, " dut_in"},   o_din,  0);
            check({tag, " busy"},     o_busy, 0);
            check({tag, " done"},     o_done, 0);
            check({tag, " pass"},     o_pass, 0);
            check({tag, " err_cnt"},  o_ec,   0);
            check({tag, " fail_idx"}, o_fi,   0);
            check({tag, " obs_mask"}, o_om,   0);
        end
    endtask

    // Caller is at a negedge; the sweep is accepted on the next posedge.
    task automatic run_sweep(input int s, input logic [7:0] flt, input bit repulse, input bit hold);
        logic [7:0] gold, exp_mask;
        int         win, exp_err, exp_fi, last_v, e_done, exp_v;
        bit         found;
        gold     = golden_mask();
        win      = (s == 1) ? 2 : 3;
        exp_mask = '0;
        exp_err  = 0;
        exp_fi   = 0;
        last_v   = 7;
        found    = 0;
        for (int v = 0; v < 8; v++) begin
            exp_mask[v] = gold[v] ^ flt[v];
            if (flt[v]) begin
                exp_err++;
                if (!found) begin
                    exp_fi = v;
                    found  = 1;
`ifdef SWEEP_STOP_ON_FAIL_EN
                    last_v = v;
                    break;
`endif
                end
            end
        end
        e_done = (last_v + 1) * win;

        sel   = s;
        fault = flt;
        drive_start(s, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive_start(s, hold);
        check("accept busy",     o_busy, 1);
        check("accept pass",     o_pass, 0);
        check("accept obs_mask", o_om,   0);
        check("accept err_cnt",  o_ec,   0);
        check("accept fail_idx", o_fi,   0);
        check("accept dut_in",   o_din,  0);

        for (int e = 1; e <= e_done; e++) begin
            drive_start(s, hold || (repulse && (e == 3 || e == 10)));
            @(negedge clk);
            exp_v = e / win;
            if (exp_v > last_v) exp_v = last_v;
            check($sformatf("dut_in edge %0d", e), o_din, exp_v);
            check($sformatf("done edge %0d", e),   o_done, (e == e_done));
            check($sformatf("busy edge %0d", e),   o_busy, 1);
        end
        check("result obs_mask", o_om, exp_mask);
        check("result err_cnt",  o_ec, exp_err);
        check("result fail_idx", o_fi, exp_fi);

        drive_start(s, hold);
        @(negedge clk);
        check("after done",     o_done, 0);
        check("after busy",     o_busy, 0);
        check("after pass",     o_pass, (exp_mask == gold));
        check("after obs_mask", o_om,   exp_mask);
        check("after err_cnt",  o_ec,   exp_err);
        check("after dut_in",   o_din,  last_v);
    endtask

    initial begin
        logic [7:0] gold;
        gold = golden_mask();

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases on the default-settle instance.
        run_sweep(0, 8'h00, 0, 0);
        run_sweep(0, gold,  0, 0);
        run_sweep(0, 8'h20, 0, 0);
        run_sweep(0, 8'h00, 1, 0);
        run_sweep(0, 8'h81, 0, 1);
        run_sweep(0, 8'h00, 0, 1);
        run_sweep(0, 8'h10, 0, 0);

        // Asynchronous reset while vector 4 is on the bus.
        sel    = 0;
        fault  = 8'h00;
        start0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("pre-reset dut_in", din0, 4);
        #1 rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_sweep(0, 8'h00, 0, 0);

        repeat (6) begin
            logic [7:0] f;
            f = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 255)) : 8'h00;
            run_sweep(0, f, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        run_sweep(0, 8'h00, 0, 0);

        // Single-cycle settle instance.
        run_sweep(1, 8'h00, 0, 0);
        run_sweep(1, 8'h20, 1, 0);
        repeat (4) begin
            run_sweep(1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
        end
        run_sweep(1, gold, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
